pipe_stall_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core.
- Detects RAW hazards between the instruction in ID and the destinations in EXE/MEM, and drives the ID freeze/bubble input.
- Flushes IF/ID on taken branches.
- Holds the back half of the pipeline while the data-memory controller is busy, with a timeout watchdog and a hazard-cycle statistics counter.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_stall_ctrl_if.sv | 45 ++++
 rtl/hazard_detect.sv | 45 ++++
 rtl/pipe_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the pipeline stall controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  // Source hits a producer only when the producer actually writes back.
  function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dest,
                                   input logic             wb_en);
    return (src == dest) & wb_en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_if
// Brief    : Pipeline-to-sequencer bundle: stage register info in, controls out.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_src2_check;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             freeze_pc;
  logic             bubble_id;
  logic             flush;
  logic             hold_back;
  logic             mem_error;
  logic [CNT_W-1:0] hazard_cycles;

  modport master (
    output id_src1, id_src2, id_src2_check, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    input  freeze_pc, bubble_id, flush, hold_back, mem_error, hazard_cycles
  );

  modport slave (
    input  id_src1, id_src2, id_src2_check, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    output freeze_pc, bubble_id, flush, hold_back, mem_error, hazard_cycles
  );

endinterface
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational RAW hazard check of ID sources against EXE/MEM dests.
//            PIPE_FORWARDING_EN reduces the check to EXE load-use only.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src2_check,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);

`ifdef PIPE_FORWARDING_EN
  // ALU results are forwarded; only a load in EXE cannot be bypassed in time.
  logic w_exe_load;
  logic w_unused_mem;

  assign w_exe_load   = exe_mem_read & exe_wb_en & (exe_dest != REG_ZERO);
  assign hazard       = w_exe_load &
                        ((id_src1 == exe_dest) | (id_src2_check & (id_src2 == exe_dest)));
  assign w_unused_mem = ^{mem_dest, mem_wb_en};
`else
  logic w_match1;
  logic w_match2;
  logic w_unused_load;

  assign w_match1 = (id_src1 != REG_ZERO) &
                    (reg_hit(id_src1, exe_dest, exe_wb_en) | reg_hit(id_src1, mem_dest, mem_wb_en));
  assign w_match2 = id_src2_check & (id_src2 != REG_ZERO) &
                    (reg_hit(id_src2, exe_dest, exe_wb_en) | reg_hit(id_src2, mem_dest, mem_wb_en));
  assign hazard        = w_match1 | w_match2;
  assign w_unused_load = exe_mem_read;
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : 5-stage pipeline sequencer: RAW stall, branch flush, memory hold
//            with timeout watchdog, saturating hazard-cycle counter.
//            Optional macro: PIPE_FORWARDING_EN (load-use-only hazards).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam int                  c_WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};

  state_t              r_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_mem_error;
  logic [CNT_W-1:0]    r_hazard_cycles;

  logic w_hazard;
  logic w_mem_stall;
  logic w_freeze_pc;
  logic w_bubble_id;
  logic w_flush;
  logic w_hold_back;
  logic w_count;

  hazard_detect u_hazard_detect (
    .id_src1       (bus.id_src1),
    .id_src2       (bus.id_src2),
    .id_src2_check (bus.id_src2_check),
    .exe_dest      (bus.exe_dest),
    .exe_wb_en     (bus.exe_wb_en),
    .exe_mem_read  (bus.exe_mem_read),
    .mem_dest      (bus.mem_dest),
    .mem_wb_en     (bus.mem_wb_en),
    .hazard        (w_hazard)
  );

  // Once waiting, only mem_ready matters; the request is already latched downstream.
  assign w_mem_stall = !bus.mem_ready & ((r_state == MEM_WAIT) | bus.mem_req);

  always_comb begin
    w_freeze_pc = 1'b0;
    w_bubble_id = 1'b0;
    w_flush     = 1'b0;
    w_hold_back = 1'b0;
    case (r_state)
      RUN, MEM_WAIT: begin
        if (w_mem_stall) begin
          w_hold_back = 1'b1;
          w_freeze_pc = 1'b1;
        end else if (bus.branch_taken) begin
          w_flush = 1'b1;
        end else if (w_hazard) begin
          w_freeze_pc = 1'b1;
          w_bubble_id = 1'b1;
        end
      end
      ERROR: begin
        w_freeze_pc = 1'b1;
        w_hold_back = 1'b1;
        w_bubble_id = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      w_freeze_pc = 1'b0;
      w_bubble_id = 1'b0;
      w_flush     = 1'b0;
      w_hold_back = 1'b0;
    end
  end

  // The ERROR bubble is a fault hold, not a hazard stall.
  assign w_count = w_bubble_id & (r_state != ERROR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= RUN;
      r_wait_cnt      <= '0;
      r_mem_error     <= 1'b0;
      r_hazard_cycles <= '0;
    end else begin
      if (w_count && (r_hazard_cycles != c_CNT_MAX)) begin
        r_hazard_cycles <= r_hazard_cycles + CNT_W'(1);
      end
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_state     <= ERROR;
            r_mem_error <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
          end
        end
        ERROR: ;
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.freeze_pc     = w_freeze_pc;
  assign bus.bubble_id     = w_bubble_id;
  assign bus.flush         = w_flush;
  assign bus.hold_back     = w_hold_back;
  assign bus.mem_error     = r_mem_error;
  assign bus.hazard_cycles = r_hazard_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Brief    : Directed self-checking bench for pipe_stall_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Packed as {freeze_pc, bubble_id, flush, hold_back, mem_error}
  localparam logic [4:0] O_NONE  = 5'b00000;
  localparam logic [4:0] O_HAZ   = 5'b11000;
  localparam logic [4:0] O_FLUSH = 5'b00100;
  localparam logic [4:0] O_MEM   = 5'b10010;
  localparam logic [4:0] O_ERR   = 5'b11011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] exp);
    check(tag, 32'({bus.freeze_pc, bus.bubble_id, bus.flush, bus.hold_back, bus.mem_error}),
          32'(exp));
  endtask

  task automatic chk_cnt(input string tag);
    check(tag, 32'(bus.hazard_cycles), 32'(exp_cnt));
  endtask

  task automatic chk_state(input string tag, input state_t s);
    check(tag, 32'(dut.r_state), 32'(s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_src1       = '0;
    bus.id_src2       = '0;
    bus.id_src2_check = 1'b0;
    bus.exe_dest      = '0;
    bus.exe_wb_en     = 1'b0;
    bus.exe_mem_read  = 1'b0;
    bus.mem_dest      = '0;
    bus.mem_wb_en     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_ready     = 1'b0;
  endtask

  task automatic set_load_use();
    bus.id_src1      = 5'd5;
    bus.exe_dest     = 5'd5;
    bus.exe_wb_en    = 1'b1;
    bus.exe_mem_read = 1'b1;
  endtask

  task automatic hz_step(input string tag, input bit stall);
    #1;
    chk_outs(tag, stall ? O_HAZ : O_NONE);
    tick();
    if (stall && exp_cnt < CNT_MAX) exp_cnt++;
    chk_cnt(tag);
  endtask

  initial begin
    clear_inputs();
    bus.id_src1   = 5'd5;
    bus.exe_dest  = 5'd5;
    bus.exe_wb_en = 1'b1;
    #2;
    chk_outs("reset_outs", O_NONE);
    chk_cnt("reset_cnt");
    chk_state("reset_state", RUN);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    hz_step("exe_raw", !FWD);
    bus.exe_mem_read = 1'b1;
    hz_step("exe_load_use", 1'b1);

    clear_inputs();
    bus.exe_wb_en = 1'b1;
    hz_step("zero_reg", 1'b0);

    clear_inputs();
    bus.id_src2   = 5'd7;
    bus.mem_dest  = 5'd7;
    bus.mem_wb_en = 1'b1;
    hz_step("src2_unchecked", 1'b0);
    bus.id_src2_check = 1'b1;
    hz_step("src2_checked_mem", !FWD);

    clear_inputs();
    bus.id_src1  = 5'd3;
    bus.exe_dest = 5'd3;
    hz_step("no_wb_en", 1'b0);

    clear_inputs();
    set_load_use();
    bus.branch_taken = 1'b1;
    #1 chk_outs("branch_beats_hazard", O_FLUSH);
    tick();
    chk_cnt("branch_cnt");

    clear_inputs();
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b1;
    #1 chk_outs("mem_ready_now", O_NONE);
    tick();
    chk_state("mem_ready_now_state", RUN);

    // Load-use and branch present throughout the wait; the hold dominates both.
    clear_inputs();
    set_load_use();
    bus.branch_taken = 1'b1;
    bus.mem_req      = 1'b1;
    #1 chk_outs("memwait_c1", O_MEM);
    tick();
    chk_state("memwait_state", MEM_WAIT);
    chk_outs("memwait_c2", O_MEM);
    tick();
    chk_outs("memwait_c3", O_MEM);
    tick();
    bus.mem_ready = 1'b1;
    #1 chk_outs("memwait_ready", O_FLUSH);
    tick();
    chk_state("memwait_exit_state", RUN);
    chk_cnt("memwait_cnt");
    clear_inputs();
    #1 chk_outs("idle_after_wait", O_NONE);

    bus.mem_req = 1'b1;
    #1 chk_outs("timeout_entry", O_MEM);
    tick();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      chk_state("timeout_wait_state", MEM_WAIT);
      chk_outs("timeout_wait_outs", O_MEM);
      tick();
    end
    chk_state("error_state", ERROR);
    chk_outs("error_outs", O_ERR);
    bus.mem_ready = 1'b1;
    tick();
    chk_state("error_sticky_state", ERROR);
    chk_outs("error_sticky_outs", O_ERR);
    chk_cnt("error_cnt");

    rst = 1'b0;
    exp_cnt = 0;
    #1;
    chk_outs("async_rst_outs", O_NONE);
    chk_cnt("async_rst_cnt");
    chk_state("async_rst_state", RUN);
    clear_inputs();
    tick();
    rst = 1'b1;

    set_load_use();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp_cnt < CNT_MAX) exp_cnt++;
      if (i == 14) chk_cnt("sat_reach");
    end
    chk_cnt("sat_hold");
    check("sat_value", 32'(bus.hazard_cycles), 32'd15);
    chk_outs("sat_still_stalling", O_HAZ);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
